// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the master view; the byte source and Imem use the slave view.
`timescale 1ns/1ps
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream into Imem and holds the core
// in reset until the image is complete. Define IMEM_LOADER_CHECKSUM_EN for a trailer checksum.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW    = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WLAST, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t          state_reg;
  logic            in_ready_reg;
  logic            imem_we_reg;
  logic [31:0]     imem_addr_reg;
  logic [31:0]     imem_wdata_reg;
  logic            core_rst_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic [7:0]      len_lo_reg;
  logic [ADDR_W:0] word_idx_reg;
  logic [ADDR_W:0] last_idx_reg;
  logic [1:0]      byte_idx_reg;
  logic [23:0]     word_buf_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum_reg;
`endif

  logic        accept;
  logic [15:0] len_word;
  logic        len_bad;

  assign accept   = bus.in_valid & in_ready_reg;
  assign len_word = {bus.in_data, len_lo_reg};
  assign len_bad  = (len_word == 16'd0) || (32'(len_word) > 32'(DEPTH));

  assign bus.in_ready   = in_ready_reg;
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_addr  = imem_addr_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign core_rst       = core_rst_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err            = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      in_ready_reg   <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= 32'd0;
      imem_wdata_reg <= 32'd0;
      core_rst_reg   <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      len_lo_reg     <= 8'd0;
      word_idx_reg   <= '0;
      last_idx_reg   <= '0;
      byte_idx_reg   <= 2'd0;
      word_buf_reg   <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_reg        <= 8'd0;
`endif
    end else begin
      imem_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg    <= S_LEN0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            core_rst_reg <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= 8'd0;
`endif
          end
        end
        S_LEN0: begin
          if (accept) begin
            len_lo_reg <= bus.in_data;
            state_reg  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            if (len_bad) begin
              state_reg    <= S_ERR;
              err_reg      <= 1'b1;
              busy_reg     <= 1'b0;
              in_ready_reg <= 1'b0;
            end else begin
              last_idx_reg <= IW'(len_word - 16'd1);
              word_idx_reg <= '0;
              byte_idx_reg <= 2'd0;
              state_reg    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= sum_reg + bus.in_data;
`endif
            case (byte_idx_reg)
              2'd0: word_buf_reg[7:0]   <= bus.in_data;
              2'd1: word_buf_reg[15:8]  <= bus.in_data;
              2'd2: word_buf_reg[23:16] <= bus.in_data;
              default: begin
                imem_we_reg    <= 1'b1;
                imem_wdata_reg <= {bus.in_data, word_buf_reg};
                imem_addr_reg  <= {{(30-ADDR_W){1'b0}}, word_idx_reg[ADDR_W-1:0], 2'b00};
                if (word_idx_reg == last_idx_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_reg    <= S_CSUM;
`else
                  // Stop accepting while the final write is on the bus.
                  state_reg    <= S_WLAST;
                  in_ready_reg <= 1'b0;
`endif
                end else begin
                  word_idx_reg <= word_idx_reg + 1'b1;
                end
              end
            endcase
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            if (bus.in_data == sum_reg) begin
              state_reg    <= S_DONE;
              done_reg     <= 1'b1;
              core_rst_reg <= 1'b0;
            end else begin
              state_reg <= S_ERR;
              err_reg   <= 1'b1;
            end
          end
        end
`else
        S_WLAST: begin
          state_reg    <= S_DONE;
          done_reg     <= 1'b1;
          core_rst_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2): table of whole-image loads plus
// hand-written timing, mid-load start, mid-load reset and checksum sequences.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 0;
`else
  localparam int DONE_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_rst, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [7:0] sum_acc;
  int wait_cycles;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  typedef struct {
    logic [143:0] bytes;
    int           nbytes;
    bit           stall;
    bit           exp_done;
    int           nwords;
    logic [127:0] words;
  } vec_t;
  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int cnt;
    for (int g = 0; g < gap; g++) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    cnt = 0;
    do begin
      acc = bus.in_ready;
      tick();
      cnt++;
    end while (!acc && cnt < 50);
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=0 required 1 for byte 0x%02h", b);
    end
  endtask

  // Sends length + payload (bytes right-aligned, first byte leftmost), then the trailer if enabled.
  task automatic load_bytes(input logic [143:0] bytes, input int n, input bit stall, input bit trailer);
    logic [7:0] b;
    sum_acc = 8'd0;
    for (int k = 0; k < n; k++) begin
      b = bytes[8*(n-1-k) +: 8];
      send_byte(b, (stall && (k % 2 == 1)) ? 2 : 0);
      if (k >= 2) sum_acc = sum_acc + b;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (trailer) send_byte(sum_acc, 0);
`else
    if (trailer) sum_acc = 8'd0;
`endif
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_start_done"}, 32'(done), 32'd0);
    chk({tag, "_start_err"}, 32'(err), 32'd0);
    chk({tag, "_start_core_rst"}, 32'(core_rst), 32'd1);
  endtask

  task automatic wait_end(input string tag);
    wait_cycles = 0;
    while (!(done || err) && wait_cycles < 40) begin
      tick();
      wait_cycles++;
    end
    if (!(done || err)) begin
      checks++;
      failures++;
      $display("FAIL %s_end_timeout: done|err=0 required 1", tag);
    end
  endtask

  task automatic chk_writes(input string tag, input int nw, input logic [127:0] words);
    chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(nw));
    for (int j = 0; j < nw && j < wr_addr_q.size(); j++) begin
      chk($sformatf("%s_addr%0d", tag, j), wr_addr_q[j], 32'(j * 4));
      chk($sformatf("%s_data%0d", tag, j), wr_data_q[j], words[32*(nw-1-j) +: 32]);
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{bytes: 144'h0100_1305_A000, nbytes: 6, stall: 1'b0, exp_done: 1'b1,
                nwords: 1, words: 128'h00A00513};
    vecs[1] = '{bytes: 144'h0300_1122_3344_5566_7788_DEAD_BEEF, nbytes: 14, stall: 1'b1,
                exp_done: 1'b1, nwords: 3, words: 128'h44332211_88776655_EFBEADDE};
    vecs[2] = '{bytes: 144'h0000, nbytes: 2, stall: 1'b0, exp_done: 1'b0, nwords: 0, words: 128'h0};
    vecs[3] = '{bytes: 144'h0500, nbytes: 2, stall: 1'b0, exp_done: 1'b0, nwords: 0, words: 128'h0};
    vecs[4] = '{bytes: 144'h0001, nbytes: 2, stall: 1'b0, exp_done: 1'b0, nwords: 0, words: 128'h0};
    vecs[5] = '{bytes: 144'h0400_0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, nbytes: 18,
                stall: 1'b0, exp_done: 1'b1, nwords: 4,
                words: 128'h03020100_07060504_0B0A0908_0F0E0D0C};

    // Reset values, then in_valid activity while IDLE must be ignored.
    tick();
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_nwrites", 32'(wr_addr_q.size()), 32'd0);
    chk("idle_core_rst", 32'(core_rst), 32'd1);
    $display("txn reset/idle: core_rst=%0d in_ready=%0d", core_rst, bus.in_ready);

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      clear_writes();
      do_start(tag);
      load_bytes(vecs[i].bytes, vecs[i].nbytes, vecs[i].stall, vecs[i].exp_done);
      wait_end(tag);
      chk({tag, "_latency"}, 32'(wait_cycles), vecs[i].exp_done ? 32'(DONE_LAT) : 32'd0);
      chk({tag, "_done"}, 32'(done), 32'(vecs[i].exp_done));
      chk({tag, "_err"}, 32'(err), 32'(!vecs[i].exp_done));
      chk({tag, "_core_rst"}, 32'(core_rst), 32'(!vecs[i].exp_done));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
      chk_writes(tag, vecs[i].nwords, vecs[i].words);
      $display("txn %s: writes=%0d done=%0d err=%0d core_rst=%0d",
               tag, wr_addr_q.size(), done, err, core_rst);
    end

    // Exact write/DONE timing for a single word.
    clear_writes();
    do_start("tim");
    load_bytes(144'h0100_1305_A000, 6, 1'b0, 1'b0);
    chk("tim_we", 32'(bus.imem_we), 32'd1);
    chk("tim_addr", bus.imem_addr, 32'd0);
    chk("tim_wdata", bus.imem_wdata, 32'h00A00513);
    chk("tim_done_early", 32'(done), 32'd0);
    chk("tim_busy_at_we", 32'(busy), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hB8, 0);
`else
    tick();
`endif
    chk("tim_we_one_cycle", 32'(bus.imem_we), 32'd0);
    chk("tim_done", 32'(done), 32'd1);
    chk("tim_core_rst", 32'(core_rst), 32'd0);
    chk("tim_busy_end", 32'(busy), 32'd0);
    $display("txn timing: done=%0d core_rst=%0d", done, core_rst);

    // start pulsed mid-load is ignored.
    clear_writes();
    do_start("mid");
    load_bytes(144'h0200_AABB_CCDD, 6, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h18, 0);
`endif
    wait_end("mid");
    chk("mid_done", 32'(done), 32'd1);
    tick();
    chk_writes("mid", 2, 128'hDDCCBBAA_04030201);
    $display("txn midstart: writes=%0d done=%0d", wr_addr_q.size(), done);

    // Asynchronous reset after two of four words.
    clear_writes();
    do_start("arst");
    load_bytes(144'h0400_1011_1213_1415_1617, 10, 1'b0, 1'b0);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_core_rst", 32'(core_rst), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("arst_imem_addr", bus.imem_addr, 32'd0);
    chk("arst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk_writes("arst", 2, 128'h13121110_17161514);
    tick();
    rst_n = 1'b1;
    tick();
    clear_writes();
    do_start("reload");
    load_bytes(144'h0100_1305_A000, 6, 1'b0, 1'b1);
    wait_end("reload");
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_core_rst", 32'(core_rst), 32'd0);
    tick();
    chk_writes("reload", 1, 128'h00A00513);
    $display("txn reset-midload/reload: writes=%0d done=%0d", wr_addr_q.size(), done);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad trailer: word still written, core stays in reset.
    clear_writes();
    do_start("csum_bad");
    load_bytes(144'h0100_1305_A000, 6, 1'b0, 1'b0);
    send_byte(8'hB9, 0);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
    chk("csum_bad_core_rst", 32'(core_rst), 32'd1);
    tick();
    chk_writes("csum_bad", 1, 128'h00A00513);
    $display("txn checksum B9: err=%0d core_rst=%0d", err, core_rst);

    clear_writes();
    do_start("csum_ok");
    load_bytes(144'h0100_1305_A000, 6, 1'b0, 1'b0);
    send_byte(8'hB8, 0);
    chk("csum_ok_done", 32'(done), 32'd1);
    chk("csum_ok_err", 32'(err), 32'd0);
    chk("csum_ok_core_rst", 32'(core_rst), 32'd0);
    $display("txn checksum B8: done=%0d core_rst=%0d", done, core_rst);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
